// File: rtl/gen_lane_swap_pipe.sv
// gen_lane_swap_pipe: single-stage valid/ready pipeline that routes a/b to y/z per lane.
// Optional transfer counter (cnt_clr, beat_cnt) is built when GEN_LANE_SWAP_STATS_EN is defined.
module gen_lane_swap_pipe #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      LANES     = 4,
    parameter logic [LANES-1:0] SEL_RESET = {LANES{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    input  logic             cfg_we,
    input  logic [LANES-1:0] cfg_sel,
    input  logic             cfg_auto,
    output logic [LANES-1:0] sel_q
`ifdef GEN_LANE_SWAP_STATS_EN
    ,
    input  logic             cnt_clr,
    output logic [15:0]      beat_cnt
`endif
);

    localparam int unsigned LW = WIDTH / LANES;

    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] z_r;
    logic             out_valid_r;
    logic [LANES-1:0] sel_r;
    logic [WIDTH-1:0] y_nxt_s;
    logic [WIDTH-1:0] z_nxt_s;
    logic             accept_s;
    logic             xfer_s;

    if ((WIDTH % LANES) != 32'd0) begin : g_bad_lanes
        $error("gen_lane_swap_pipe: WIDTH must be a multiple of LANES");
    end

    // Lane k takes a on y when its select bit is set, otherwise b; z gets the other input.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign y_nxt_s[k*LW +: LW] = sel_r[k] ? a[k*LW +: LW] : b[k*LW +: LW];
        assign z_nxt_s[k*LW +: LW] = sel_r[k] ? b[k*LW +: LW] : a[k*LW +: LW];
    end

    assign in_ready  = ~out_valid_r | out_ready;
    assign accept_s  = in_valid & in_ready;
    assign xfer_s    = out_valid_r & out_ready;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign z         = z_r;
    assign sel_q     = sel_r;

    // Output data register: loads only on an accepted beat, so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r <= {WIDTH{1'b0}};
            z_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            y_r <= y_nxt_s;
            z_r <= z_nxt_s;
        end
    end

    // Output valid: set on accept, dropped only when a transfer is not refilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
        end else if (xfer_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Select register: config write beats the ping-pong toggle; the mux above sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r <= SEL_RESET;
        end else if (cfg_we) begin
            sel_r <= cfg_sel;
        end else if (cfg_auto && accept_s) begin
            sel_r <= ~sel_r;
        end
    end

`ifdef GEN_LANE_SWAP_STATS_EN
    logic [15:0] beat_cnt_r;

    // Output transfer counter, wraps naturally; a clear wins over a coincident transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= 16'd0;
        end else if (cnt_clr) begin
            beat_cnt_r <= 16'd0;
        end else if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + 16'd1;
        end
    end

    assign beat_cnt = beat_cnt_r;
`endif

endmodule
